// File: rtl/hall_tach_if.sv
`default_nettype none
// ============================================================================
// Module   : hall_tach_if
// Purpose  : Control and result bundle between the hall tachometer and its user.
// Revision : 1.0
// ============================================================================
interface hall_tach_if #(
    parameter int CNT_W = 16
);
    logic             sa_in;
    logic             enable;
    logic             clear;
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             edge_pulse;
    logic             overflow;

    modport master (
        output sa_in,
        output enable,
        output clear,
        input  count_out,
        input  count_valid,
        input  edge_pulse,
        input  overflow
    );

    modport slave (
        input  sa_in,
        input  enable,
        input  clear,
        output count_out,
        output count_valid,
        output edge_pulse,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/hall_tach.sv
`default_nettype none
// ============================================================================
// Module   : hall_tach
// Purpose  : Hall sensor tachometer: synchronise, glitch-filter, count rising
//            edges per fixed window. Optional macro HALL_AVG_EN averages the
//            last four window counts.
// Revision : 1.0
// ============================================================================
module hall_tach #(
    parameter int WINDOW_CYCLES = 10_000_000,
    parameter int FILT_LEN      = 4,
    parameter int CNT_W         = 16
) (
    input  wire logic   clk,
    input  wire logic   resetn,
    hall_tach_if.slave  bus
);
    localparam int                c_ww        = $clog2(WINDOW_CYCLES);
    localparam int                c_fw        = $clog2(FILT_LEN + 1);
    localparam logic [c_ww-1:0]   c_win_last  = c_ww'(WINDOW_CYCLES - 1);
    localparam logic [c_fw-1:0]   c_filt_last = c_fw'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};

    logic             r_s1;
    logic             r_s2;
    logic             r_filt;
    logic             r_filt_d;
    logic [c_fw-1:0]  r_filt_cnt;
    logic             r_edge_pulse;

    logic [c_ww-1:0]  r_wcnt;
    logic [CNT_W-1:0] r_ecnt;
    logic             r_ovf_w;

    logic [CNT_W-1:0] r_count_out;
    logic             r_count_valid;
    logic             r_overflow;

    logic             w_inc;
    logic             w_sat;
    logic             w_term;
    logic [CNT_W-1:0] w_cnt_final;
    logic             w_ovf_final;
    logic [CNT_W-1:0] w_out_cnt;
    logic             w_out_ovf;

    // Filter and synchroniser run independently of enable/clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_filt       <= 1'b0;
            r_filt_d     <= 1'b0;
            r_filt_cnt   <= '0;
            r_edge_pulse <= 1'b0;
        end else begin
            r_s1         <= bus.sa_in;
            r_s2         <= r_s1;
            r_filt_d     <= r_filt;
            r_edge_pulse <= r_filt & ~r_filt_d;
            if (r_s2 != r_filt) begin
                if (r_filt_cnt == c_filt_last) begin
                    r_filt     <= r_s2;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + c_fw'(1);
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_inc       = r_edge_pulse & bus.enable & ~bus.clear;
        w_sat       = (r_ecnt == c_cnt_max);
        w_term      = bus.enable & ~bus.clear & (r_wcnt == c_win_last);
        w_cnt_final = (w_inc && !w_sat) ? r_ecnt + CNT_W'(1) : r_ecnt;
        w_ovf_final = r_ovf_w | (w_inc & w_sat);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wcnt  <= '0;
            r_ecnt  <= '0;
            r_ovf_w <= 1'b0;
        end else if (bus.clear || !bus.enable || w_term) begin
            r_wcnt  <= '0;
            r_ecnt  <= '0;
            r_ovf_w <= 1'b0;
        end else begin
            r_wcnt  <= r_wcnt + c_ww'(1);
            r_ecnt  <= w_cnt_final;
            r_ovf_w <= w_ovf_final;
        end
    end

`ifdef HALL_AVG_EN
    // Three previous window results; the closing window supplies the fourth term.
    logic [CNT_W-1:0] r_hist_0;
    logic [CNT_W-1:0] r_hist_1;
    logic [CNT_W-1:0] r_hist_2;
    logic [2:0]       r_hist_ovf;
    logic [CNT_W+1:0] w_sum;

    always_comb begin
        w_sum     = {2'b00, w_cnt_final} + {2'b00, r_hist_0}
                  + {2'b00, r_hist_1}    + {2'b00, r_hist_2};
        w_out_cnt = CNT_W'(w_sum >> 2);
        w_out_ovf = w_ovf_final | (|r_hist_ovf);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hist_0   <= '0;
            r_hist_1   <= '0;
            r_hist_2   <= '0;
            r_hist_ovf <= '0;
        end else if (w_term) begin
            r_hist_0   <= w_cnt_final;
            r_hist_1   <= r_hist_0;
            r_hist_2   <= r_hist_1;
            r_hist_ovf <= {r_hist_ovf[1:0], w_ovf_final};
        end
    end
`else
    always_comb begin
        w_out_cnt = w_cnt_final;
        w_out_ovf = w_ovf_final;
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count_out   <= '0;
            r_count_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_count_valid <= w_term;
            if (w_term) begin
                r_count_out <= w_out_cnt;
                r_overflow  <= w_out_ovf;
            end
        end
    end

    assign bus.count_out   = r_count_out;
    assign bus.count_valid = r_count_valid;
    assign bus.edge_pulse  = r_edge_pulse;
    assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire
